sub_sra_unit: RTL and testbench

SUB_SRA_UNIT -- requirements
Module: sub_sra_unit

---
 rtl/sub_sra_unit.sv | 100 ++++++++++
 tb/tb_sub_sra_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sub_sra_unit.sv
// Single-cycle SUB / arithmetic-shift-right unit with registered result and flags.
// The outputs hold their last values when in_valid is low, and are cleared by an asynchronous reset.
module sub_sra_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             borrow
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sub_ext;
  logic [WIDTH-1:0] sub_res;
  logic             sub_borrow;
  logic             sub_ovf;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] shift_stage [0:SHW];

  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;
  logic             overflow_q, overflow_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] op_res;

  // Subtracting zero-extended operands yields the unsigned borrow as the extra MSB.
  assign sub_ext    = {1'b0, operand_A} - {1'b0, operand_B};
  assign sub_res    = sub_ext[WIDTH-1:0];
  assign sub_borrow = sub_ext[WIDTH];
  assign sub_ovf    = (operand_A[WIDTH-1] != operand_B[WIDTH-1]) &&
                      (sub_res[WIDTH-1] != operand_A[WIDTH-1]);

  assign shamt          = operand_B[SHW-1:0];
  assign shift_stage[0] = operand_A;

  // Logarithmic barrel shifter: stage gi shifts by 2**gi, filling with the sign bit.
  generate
    for (genvar gi = 0; gi < SHW; gi++) begin : g_sra_stage
      localparam int STEP = 1 << gi;
      assign shift_stage[gi+1] = shamt[gi]
        ? {{STEP{operand_A[WIDTH-1]}}, shift_stage[gi][WIDTH-1:STEP]}
        : shift_stage[gi];
    end
  endgenerate

  assign op_res = op ? shift_stage[SHW] : sub_res;

  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    negative_d  = negative_q;
    overflow_d  = overflow_q;
    borrow_d    = borrow_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      result_d   = op_res;
      zero_d     = (op_res == '0);
      negative_d = op_res[WIDTH-1];
      overflow_d = op ? 1'b0 : sub_ovf;
      borrow_d   = op ? 1'b0 : sub_borrow;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
      borrow_q    <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      overflow_q  <= overflow_d;
      borrow_q    <= borrow_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign overflow  = overflow_q;
  assign borrow    = borrow_q;

endmodule

// File: tb/tb_sub_sra_unit.sv
// Self-checking bench for sub_sra_unit: directed vectors plus random operations
// compared against an arithmetic reference model of SUB and SRA.
module tb_sub_sra_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        op = 1'b0;
  logic [31:0] operand_A = '0;
  logic [31:0] operand_B = '0;
  logic [31:0] result;
  logic        out_valid, zero, negative, overflow, borrow;

  int checks = 0;
  int failures = 0;
  logic [36:0] last_exp = '0;  // {out_valid, zero, negative, overflow, borrow, result}

  sub_sra_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op),
    .operand_A(operand_A), .operand_B(operand_B),
    .result(result), .out_valid(out_valid), .zero(zero), .negative(negative),
    .overflow(overflow), .borrow(borrow)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] observed();
    return {out_valid, zero, negative, overflow, borrow, result};
  endfunction

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic logic [36:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, sd, p, q;
    logic [31:0] res;
    logic ov, br;
    int n;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o) begin
      q   = ua - ub;
      res = q[31:0];
      br  = (ua < ub);
      sd  = sa - sb;
      ov  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    end else begin
      n = int'(b % 32);
      p = longint'(1) << n;
      if (sa >= 0) q = sa / p;
      else         q = -((-sa + p - 1) / p);  // floor division for negatives
      res = q[31:0];
      ov  = 1'b0;
      br  = 1'b0;
    end
    return {1'b1, (res == 32'd0), res[31], ov, br, res};
  endfunction

  task automatic drive(input logic v, input logic o, input logic [31:0] a, input logic [31:0] b);
    in_valid  = v;
    op        = o;
    operand_A = a;
    operand_B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (observed() !== 37'd0) begin
      failures++;
      $display("FAIL reset_initial: got %h expected %h", observed(), 37'd0);
    end
    // Operation presented while reset is high must be discarded.
    drive(1'b1, 1'b0, 32'd0, 32'd1);
    checks++;
    if (observed() !== 37'd0) begin
      failures++;
      $display("FAIL reset_discard: got %h expected %h", observed(), 37'd0);
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd1);
    checks++;
    if (observed() !== 37'd0) begin
      failures++;
      $display("FAIL reset_release_idle: got %h expected %h", observed(), 37'd0);
    end
    last_exp = '0;
  endtask

  task automatic test_directed();
    logic        t_op  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] t_a   [10] = '{32'd5, 32'd7, 32'd0, 32'h8000_0000, 32'h8000_0000,
                                32'h8000_0000, 32'h7FFF_FFF0, 32'hFFFF_FFFF, 32'h1234_5678, 32'h7FFF_FFFF};
    logic [31:0] t_b   [10] = '{32'd3, 32'd7, 32'd1, 32'd1, 32'd4,
                                32'h24, 32'd4, 32'd31, 32'd0, 32'hFFFF_FFFF};
    // {valid, zero, negative, overflow, borrow, result}
    logic [36:0] t_exp [10] = '{
      {5'b10000, 32'd2},
      {5'b11000, 32'd0},
      {5'b10101, 32'hFFFF_FFFF},
      {5'b10010, 32'h7FFF_FFFF},
      {5'b10100, 32'hF800_0000},
      {5'b10100, 32'hF800_0000},
      {5'b10000, 32'h07FF_FFFF},
      {5'b10100, 32'hFFFF_FFFF},
      {5'b10000, 32'h1234_5678},
      {5'b10111, 32'h8000_0000}};
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, t_op[i], t_a[i], t_b[i]);
      checks++;
      if (observed() !== t_exp[i]) begin
        failures++;
        $display("FAIL directed_%0d op=%0d a=%h b=%h: got %h expected %h",
                 i, t_op[i], t_a[i], t_b[i], observed(), t_exp[i]);
      end
      last_exp = t_exp[i];
    end
  endtask

  task automatic test_random();
    logic        o;
    logic [31:0] a, b;
    logic [36:0] e;
    for (int i = 0; i < 300; i++) begin
      o = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a ^ (32'd1 << $urandom_range(0, 31)) : $urandom;
      if (i % 7 == 0) b = a;
      e = model(o, a, b);
      drive(1'b1, o, a, b);
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, observed(), e);
      end
      last_exp = e;
    end
  endtask

  task automatic test_hold();
    logic [36:0] e;
    for (int i = 0; i < 4; i++) begin
      e = {1'b0, last_exp[35:0]};
      drive(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      checks++;
      if (observed() !== e) begin
        failures++;
        $display("FAIL hold_%0d: got %h expected %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [36:0] e;
    e = model(1'b0, 32'h0000_0010, 32'h0000_0020);
    drive(1'b1, 1'b0, 32'h0000_0010, 32'h0000_0020);
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("FAIL b2b_sub: got %h expected %h", observed(), e);
    end
    e = model(1'b1, 32'h9000_0000, 32'd3);
    drive(1'b1, 1'b1, 32'h9000_0000, 32'd3);
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("FAIL b2b_sra: got %h expected %h", observed(), e);
    end
    last_exp = e;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    checks++;
    if (observed() !== {1'b0, last_exp[35:0]}) begin
      failures++;
      $display("FAIL b2b_idle: got %h expected %h", observed(), {1'b0, last_exp[35:0]});
    end
    // Mid-stream asynchronous reset, between clock edges.
    e = model(1'b0, 32'd1, 32'd9);
    drive(1'b1, 1'b0, 32'd1, 32'd9);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (observed() !== 37'd0) begin
      failures++;
      $display("FAIL async_reset: got %h expected %h (pre-reset %h)", observed(), 37'd0, e);
    end
    drive(1'b1, 1'b0, 32'd3, 32'd8);
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    checks++;
    if (observed() !== 37'd0) begin
      failures++;
      $display("FAIL no_stale_after_reset: got %h expected %h", observed(), 37'd0);
    end
    e = model(1'b0, 32'd100, 32'd58);
    drive(1'b1, 1'b0, 32'd100, 32'd58);
    checks++;
    if (observed() !== e) begin
      failures++;
      $display("FAIL first_after_reset: got %h expected %h", observed(), e);
    end
    last_exp = e;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
